// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the bit-serial adder.
//   state_e : FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   CNT_W   : bit counter width for a given operand width, never less than 1
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned CNT_W(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_add1.sv
// full_add1: single-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_add1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder, one result bit per clock.
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   start         : request; a, b, cin are sampled when accepted in IDLE or DONE
//   a, b, cin     : operands and carry-in
//   sum, cout     : registered result and carry out of the MSB
//   overflow      : registered signed overflow (carry into MSB ^ carry out of MSB)
//   busy          : high while bits are being computed
//   done          : one-cycle pulse when sum/cout/overflow are updated
module serial_adder
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CntW    = CNT_W(WIDTH);
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_shift;

  full_add1 u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New bit enters at the MSB; written this way so WIDTH=1 needs no special slice.
  always_comb begin
    sum_shift            = sum_sh_q >> 1;
    sum_shift[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            carry_q  <= cin;
            cnt_q    <= '0;
            sum_sh_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_shift;
          carry_q  <= fa_cout;
          if (cnt_q == CntLast) begin
            // carry_q is the carry into the MSB on this final edge
            sum_q   <= sum_shift;
            cout_q  <= fa_cout;
            ovf_q   <= carry_q ^ fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            // Counter holds at its last value so it never exceeds WIDTH-1.
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
